// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush control logic.
//   ctrl_state_e : front-end controller state (RUN / STALL)
//   REG_ZERO     : hard-wired zero register, never a hazard source
//   CNT_W_DEF    : default width of the debug counters
//   need_max     : larger of two stall requirements
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ctrl_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam int unsigned CNT_W_DEF = 16;

    function automatic logic [1:0] need_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_need.sv
// Combinational stall requirement for the instruction in ID.
// Ports:
//   if_id_rs/if_id_rt        : source registers of the instruction in ID
//   I_type                   : instruction does not read rt (branches always do)
//   branch/jump              : ID instruction class (jump wins if both are set)
//   id_ex_rd/_regwrite/_memread : producer in EX
//   ex_mem_rd/_memread       : producer in MEM
//   need                     : stall cycles required before ID may proceed (0..3)
module hazard_need
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALU_BR_STALL = 1,
    parameter int unsigned LD_BR_STALL  = 2
) (
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       I_type,
    input  logic       branch,
    input  logic       jump,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_regwrite,
    input  logic       id_ex_memread,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_memread,
    output logic [1:0] need
);

    logic is_branch;
    logic reads_rt;
    logic id_ex_hit;
    logic ex_mem_hit;

    always_comb begin
        // A jump+branch combination is handled as a plain jump.
        is_branch  = branch & ~jump;
        reads_rt   = is_branch | ~I_type;

        id_ex_hit  = (id_ex_rd != REG_ZERO) &&
                     ((id_ex_rd == if_id_rs) || (reads_rt && (id_ex_rd == if_id_rt)));
        ex_mem_hit = (ex_mem_rd != REG_ZERO) &&
                     ((ex_mem_rd == if_id_rs) || (reads_rt && (ex_mem_rd == if_id_rt)));

        need = 2'd0;
        if (is_branch) begin
            if (id_ex_memread && id_ex_hit)
                need = need_max(need, 2'(LD_BR_STALL));
            if (id_ex_regwrite && !id_ex_memread && id_ex_hit)
                need = need_max(need, 2'(ALU_BR_STALL));
            if (ex_mem_memread && ex_mem_hit)
                need = need_max(need, 2'd1);
        end else begin
            if (id_ex_memread && id_ex_hit)
                need = need_max(need, 2'd1);
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Front-end stall/flush controller for a 5-stage pipeline with branches
// resolved in ID. Holds PC and IF/ID until the operands needed in ID can be
// forwarded, inserts ID/EX bubbles meanwhile, and squashes the fetched
// instruction on taken branches and jumps.
// Ports:
//   clk, reset (sync, active-high)
//   ID instruction info, EX/MEM producer info (see hazard_need)
//   pc_write, if_id_write, id_ex_bubble, if_id_flush : pipeline controls
//   stalling     : controller is in the STALL state
//   stall_cycles : saturating count of cycles with pc_write low
//   flush_count  : saturating count of IF/ID flushes
module branch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALU_BR_STALL = 1,
    parameter int unsigned LD_BR_STALL  = 2,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             I_type,
    input  logic             branch,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_memread,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_memread,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_e      state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       need;

    hazard_need #(
        .ALU_BR_STALL(ALU_BR_STALL),
        .LD_BR_STALL (LD_BR_STALL)
    ) u_need (
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .I_type        (I_type),
        .branch        (branch),
        .jump          (jump),
        .id_ex_rd      (id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread (id_ex_memread),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_memread(ex_mem_memread),
        .need          (need)
    );

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        stalling     = 1'b0;

        // Outputs read as idle while reset is held, even mid-stall.
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (need == 2'd0) begin
                        if_id_flush = jump | (branch & branch_taken);
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        // The RUN cycle itself is the first stall cycle.
                        if (need > 2'd1) begin
                            state_d = STALL;
                            rem_d   = need - 2'd1;
                        end
                    end
                end
                STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stalling     = 1'b1;
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d   = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (if_id_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: table of single-cycle hazard
// vectors plus hand-written multi-cycle sequences (stall length, back-to-back
// hazards, flush counting, reset mid-stall, counter saturation).
module tb_branch_hazard_ctrl;

    typedef struct {
        logic [4:0] rs, rt;
        logic       ityp, br, jmp, tkn;
        logic [4:0] exrd;
        logic       exrw, exmr;
        logic [4:0] mmrd;
        logic       mmmr;
    } vec_t;

    typedef struct {
        string nm;
        vec_t  v;
        logic  pw;
        logic  fl;
    } tv_t;

    typedef struct {
        string nm;
        logic  pw, bub, fl, st;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic       I_type, branch, jump, branch_taken;
    logic       id_ex_regwrite, id_ex_memread, ex_mem_memread;

    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling;
    logic [3:0] stall_cycles, flush_count;
    logic       pc_write0, if_id_write0, id_ex_bubble0, if_id_flush0, stalling0;
    logic [15:0] stall_cycles0, flush_count0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    exp_t        exp_q[$];
    tv_t         tvs[14];

    always #5 clk = ~clk;

    branch_hazard_ctrl #(
        .ALU_BR_STALL(1),
        .LD_BR_STALL (2),
        .CNT_W       (4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .I_type(I_type),
        .branch(branch), .jump(jump), .branch_taken(branch_taken),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_memread(ex_mem_memread),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .stalling(stalling),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    branch_hazard_ctrl #(
        .ALU_BR_STALL(0),
        .LD_BR_STALL (2),
        .CNT_W       (16)
    ) dut0 (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .I_type(I_type),
        .branch(branch), .jump(jump), .branch_taken(branch_taken),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_memread(ex_mem_memread),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .id_ex_bubble(id_ex_bubble0),
        .if_id_flush(if_id_flush0), .stalling(stalling0),
        .stall_cycles(stall_cycles0), .flush_count(flush_count0)
    );

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic ity, input logic br, input logic jp, input logic tk,
                                input logic [4:0] exrd, input logic exrw, input logic exmr,
                                input logic [4:0] mmrd, input logic mmmr);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ityp = ity; v.br = br; v.jmp = jp; v.tkn = tk;
        v.exrd = exrd; v.exrw = exrw; v.exmr = exmr; v.mmrd = mmrd; v.mmmr = mmmr;
        return v;
    endfunction

    function automatic tv_t mktv(input string nm, input vec_t v, input logic pw, input logic fl);
        tv_t t;
        t.nm = nm; t.v = v; t.pw = pw; t.fl = fl;
        return t;
    endfunction

    task automatic set_in(input vec_t v);
        if_id_rs = v.rs; if_id_rt = v.rt; I_type = v.ityp;
        branch = v.br; jump = v.jmp; branch_taken = v.tkn;
        id_ex_rd = v.exrd; id_ex_regwrite = v.exrw; id_ex_memread = v.exmr;
        ex_mem_rd = v.mmrd; ex_mem_memread = v.mmmr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Push the expectation for this cycle, then compare at the falling edge.
    task automatic cyc(input string nm, input logic pw, input logic bub,
                       input logic fl, input logic st);
        exp_t e, g;
        e.nm = nm; e.pw = pw; e.bub = bub; e.fl = fl; e.st = st;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            g = exp_q.pop_front();
            chk({g.nm, "_pc_write"},    {31'd0, pc_write},     {31'd0, g.pw});
            chk({g.nm, "_if_id_write"}, {31'd0, if_id_write},  {31'd0, g.pw});
            chk({g.nm, "_bubble"},      {31'd0, id_ex_bubble}, {31'd0, g.bub});
            chk({g.nm, "_flush"},       {31'd0, if_id_flush},  {31'd0, g.fl});
            chk({g.nm, "_stalling"},    {31'd0, stalling},     {31'd0, g.st});
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input vec_t idle);
        reset = 1'b1;
        set_in(idle);
        adv();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        vec_t idle, ldbr, alubr, taken, jmp, untaken;
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ldbr    = mk(3, 4, 0, 1, 0, 0, 3, 1, 1, 0, 0);
        alubr   = mk(6, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0);
        taken   = mk(1, 2, 0, 1, 0, 1, 10, 1, 0, 0, 0);
        jmp     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        untaken = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        tvs[0]  = mktv("ld_br_rs",      ldbr, 0, 0);
        tvs[1]  = mktv("alu_br_rt",     alubr, 0, 0);
        tvs[2]  = mktv("ld_itype_rs",   mk(7, 8, 1, 0, 0, 0, 7, 1, 1, 0, 0), 0, 0);
        tvs[3]  = mktv("ld_itype_rt",   mk(1, 9, 1, 0, 0, 0, 9, 1, 1, 0, 0), 1, 0);
        tvs[4]  = mktv("taken_beq",     taken, 1, 1);
        tvs[5]  = mktv("jump",          jmp, 1, 1);
        tvs[6]  = mktv("untaken_br",    untaken, 1, 0);
        tvs[7]  = mktv("zero_reg",      mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0), 1, 0);
        tvs[8]  = mktv("mem_ld_br",     mk(11, 2, 0, 1, 0, 1, 0, 0, 0, 11, 1), 0, 0);
        tvs[9]  = mktv("mem_ld_nonbr",  mk(11, 2, 0, 0, 0, 0, 0, 0, 0, 11, 1), 1, 0);
        tvs[10] = mktv("alu_nonbr",     mk(12, 2, 0, 0, 0, 0, 12, 1, 0, 0, 0), 1, 0);
        tvs[11] = mktv("ld_rtype_rt",   mk(2, 13, 0, 0, 0, 0, 13, 1, 1, 0, 0), 0, 0);
        tvs[12] = mktv("ld_br_rt_ityp", mk(2, 14, 1, 1, 0, 0, 14, 1, 1, 0, 0), 0, 0);
        tvs[13] = mktv("mem_alu_br",    mk(15, 2, 0, 1, 0, 0, 0, 0, 0, 15, 0), 1, 0);

        // Reset held with hazard inputs present: outputs idle, counters clear.
        set_in(ldbr);
        reset = 1'b1;
        adv();
        adv();
        cyc("in_reset", 1, 0, 0, 0);
        chk("in_reset_stall_cnt", {28'd0, stall_cycles}, 0);
        chk("in_reset_flush_cnt", {28'd0, flush_count}, 0);
        adv();
        reset = 1'b0;

        // Table: first cycle of each vector from a settled RUN state.
        for (int i = 0; i < 14; i++) begin
            set_in(tvs[i].v);
            cyc(tvs[i].nm, tvs[i].pw, ~tvs[i].pw, tvs[i].fl, 1'b0);
            adv();
            set_in(idle);
            repeat (3) adv();
        end

        // Load feeding a branch: exactly two stall cycles.
        do_reset(idle);
        set_in(ldbr);
        cyc("ldbr_c1", 0, 1, 0, 0);
        chk("ldbr_cnt_c1", {28'd0, stall_cycles}, 0);
        adv();
        cyc("ldbr_c2", 0, 1, 0, 1);
        chk("ldbr_cnt_c2", {28'd0, stall_cycles}, 1);
        adv();
        set_in(idle);
        cyc("ldbr_c3", 1, 0, 0, 0);
        chk("ldbr_cnt_c3", {28'd0, stall_cycles}, 2);
        adv();

        // Hazard still present on return to RUN restarts with no gap.
        do_reset(idle);
        set_in(ldbr);
        cyc("b2b_c1", 0, 1, 0, 0); adv();
        cyc("b2b_c2", 0, 1, 0, 1); adv();
        cyc("b2b_c3", 0, 1, 0, 0); adv();
        cyc("b2b_c4", 0, 1, 0, 1); adv();
        set_in(idle);
        cyc("b2b_c5", 1, 0, 0, 0);
        chk("b2b_cnt", {28'd0, stall_cycles}, 4);
        adv();

        // ALU result feeding a branch: one stall (none with ALU_BR_STALL=0).
        do_reset(idle);
        set_in(alubr);
        cyc("alubr_c1", 0, 1, 0, 0);
        chk("alubr0_pc_write", {31'd0, pc_write0}, 1);
        chk("alubr0_flush", {31'd0, if_id_flush0}, 1);
        adv();
        set_in(idle);
        cyc("alubr_c2", 1, 0, 0, 0);
        chk("alubr_cnt", {28'd0, stall_cycles}, 1);
        chk("alubr0_cnt", {16'd0, stall_cycles0}, 0);
        adv();

        // Flush counting: taken branch, jump, untaken branch.
        do_reset(idle);
        set_in(taken);   cyc("fl_taken", 1, 0, 1, 0);   adv();
        set_in(jmp);     cyc("fl_jump", 1, 0, 1, 0);    adv();
        set_in(untaken); cyc("fl_untaken", 1, 0, 0, 0); adv();
        set_in(idle);
        cyc("fl_idle", 1, 0, 0, 0);
        chk("fl_cnt", {28'd0, flush_count}, 2);
        adv();

        // Reset in the STALL cycle of a two-cycle stall.
        do_reset(idle);
        set_in(ldbr);
        cyc("rstmid_c1", 0, 1, 0, 0); adv();
        reset = 1'b1;
        cyc("rstmid_c2", 1, 0, 0, 0); adv();
        reset = 1'b0;
        set_in(idle);
        cyc("rstmid_after", 1, 0, 0, 0);
        chk("rstmid_stall_cnt", {28'd0, stall_cycles}, 0);
        adv();

        // Reset in the first stall cycle.
        do_reset(idle);
        set_in(ldbr);
        reset = 1'b1;
        cyc("rst_c1", 1, 0, 0, 0); adv();
        reset = 1'b0;
        set_in(idle);
        cyc("rst_c1_after", 1, 0, 0, 0);
        chk("rst_c1_stall_cnt", {28'd0, stall_cycles}, 0);
        adv();

        // Counter saturation (4-bit counters on the main instance).
        do_reset(idle);
        set_in(ldbr);
        repeat (20) adv();
        @(negedge clk);
        chk("stall_sat", {28'd0, stall_cycles}, 15);
        adv();
        set_in(jmp);
        repeat (18) adv();
        @(negedge clk);
        chk("flush_sat", {28'd0, flush_count}, 15);
        chk("stall_sat_hold", {28'd0, stall_cycles}, 15);
        adv();

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline, with branches resolved in ID.
- The forwarding logic tells consumers where an operand comes from. This block is the producer-side counterpart: it holds the front end until every operand a branch or consumer needs can actually be forwarded.
- It drives PC / IF-ID write enables, ID-EX bubble insertion and IF-ID flush.
- It keeps saturating stall and flush counters for debug.

Parameters:
- ALU_BR_STALL, 1, stall cycles when a branch in ID reads the rd of an ALU op in ID/EX (0..3).
- LD_BR_STALL, 2, stall cycles when a branch in ID reads the rd of a load in ID/EX (0..3).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_id_rs  in  5  rs of the instruction in ID
- if_id_rt  in  5  rt of the instruction in ID
- I_type  in  1  instruction in ID does not read rt as a source (branches always read rt)
- branch  in  1  instruction in ID is a conditional branch
- jump  in  1  instruction in ID is a jump
- branch_taken  in  1  branch comparison in ID is true
- id_ex_rd  in  5  destination register in EX
- id_ex_regwrite  in  1  instruction in EX writes a register
- id_ex_memread  in  1  instruction in EX is a load
- ex_mem_rd  in  5  destination register in MEM
- ex_mem_memread  in  1  instruction in MEM is a load
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register load enable
- id_ex_bubble  out  1  zero the control fields entering ID/EX
- if_id_flush  out  1  squash the instruction being fetched
- stalling  out  1  FSM is in the STALL state
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flushes

Behaviour:
- Register 0 never causes a hazard.
- Source-read rules: rs is always read. rt is read when branch=1 or I_type=0.
- Hazard requirement N, computed combinationally as the maximum over the rules below (0 if none apply):
  - load in ID/EX, rd read by a branch: N = LD_BR_STALL
  - ALU op (regwrite=1, memread=0) in ID/EX, rd read by a branch: N = ALU_BR_STALL
  - load in EX/MEM, rd read by a branch: N = 1
  - load in ID/EX, rd read by a non-branch instruction: N = 1
- FSM states: RUN and STALL. A 2-bit register rem holds the stall cycles remaining.
- RUN with N = 0:
  - pc_write=1, if_id_write=1, id_ex_bubble=0.
  - if_id_flush = jump OR (branch AND branch_taken), combinational in the same cycle.
  - flush_count increments on each flush.
- RUN with N > 0:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. Branch outcome is ignored (operands not yet valid).
  - Next state is STALL with rem = N-1 if N > 1; otherwise stay in RUN.
- STALL:
  - Same outputs as a stalled RUN cycle; stalling=1.
  - Hazard inputs are ignored.
  - rem decrements each cycle. When rem = 0 the next state is RUN.
  - Total stall length is exactly N cycles.
- Back-to-back hazards: on re-entering RUN, detection is evaluated fresh. A new hazard restarts the sequence with no gap cycle.
- stall_cycles increments on every cycle with pc_write=0. Both counters saturate at all-ones.
- Reset:
  - Synchronous, effective at the clock edge, including mid-stall.
  - state=RUN, rem=0, both counters=0.
  - Outputs during and after reset: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, stalling=0.
- jump and branch both asserted is illegal; treated as jump.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, STALL), REG_ZERO constant, CNT_W default.
- One sub-module, hazard_need (combinational N computation), reusable by the forwarding/debug logic.
- FSM and counters stay in this module.

Test Plan:
- lw $3 in EX, beq $3,$4 in ID, defaults -> pc_write=0 for exactly 2 cycles; id_ex_bubble=1 in both; stalling=1 only in cycle 2; stall_cycles=2.
- add $5 in EX, bne $6,$5 in ID -> exactly 1 stall cycle, stalling stays 0; with ALU_BR_STALL=0 -> no stall.
- lw $7 in EX, addi $8,$7,4 in ID (I_type=1); repeat with lw $9 in EX and rt=$9, I_type=1 -> 1 stall for the first case, no stall for the second.
- Taken beq with no hazard, then jump -> if_id_flush=1 in each of those cycles; flush_count=2; a not-taken branch gives no flush.
- id_ex_rd=0 with load, branch reading $0 -> no stall. Force stall_cycles to all-ones -> it holds at all-ones.
- reset asserted during cycle 1 of a 2-cycle stall -> next cycle state RUN, pc_write=1, counters=0.
